// File: rtl/div_arb_ctrl.sv
// Round-robin sequencer sharing one load-then-iterate divider between two requesters.
// Optional divide-by-zero short-circuit enabled by defining DIV_ARB_DZCHK_EN.
module div_arb_ctrl #(
  parameter int unsigned W       = 4,
  parameter int unsigned DIV_LAT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] q,
  output logic         dz,
  output logic         busy,
  output logic         div_ld,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_y
);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e       state_q, state_d;
  logic         gnt_d, gnt_q;
  logic         prio_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] a_q, b_q, q_q;
  logic         dz_q;
  logic         any_req;
  logic [W-1:0] sel_a, sel_b;
  logic         dz_hit;

  assign any_req = req0 | req1;
  // prio_q names the requester that wins a tie
  assign gnt_d   = (req0 && req1) ? prio_q : ~req0;
  assign sel_a   = gnt_d ? a1 : a0;
  assign sel_b   = gnt_d ? b1 : b0;

`ifdef DIV_ARB_DZCHK_EN
  assign dz_hit = (sel_b == '0);
`else
  assign dz_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = dz_hit ? StDone : StLoad;
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q  <= 1'b0;
      prio_q <= 1'b0;
      cnt_q  <= 4'd0;
      a_q    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q <= gnt_d;
            a_q   <= sel_a;
            b_q   <= sel_b;
            dz_q  <= dz_hit;
            if (dz_hit) begin
              q_q <= '1;
            end
          end
        end
        StLoad: cnt_q <= 4'(DIV_LAT);
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            q_q  <= div_y;
            dz_q <= 1'b0;
          end
        end
        StDone: prio_q <= ~gnt_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    div_ld = (state_q == StLoad);
    done0  = (state_q == StDone) && !gnt_q;
    done1  = (state_q == StDone) && gnt_q;
    dz     = (state_q == StDone) && dz_q;
    q      = q_q;
    div_a  = a_q;
    div_b  = b_q;
  end

endmodule

// File: doc/div_arb_ctrl.md
Name: div_arb_ctrl

Overview:
Sequencing controller and two-way round-robin arbiter that shares one sequential 4-bit divider (load-then-iterate, quotient valid a fixed number of cycles after load) between two requesters. It accepts level requests with operands, latches the winning operands, pulses the divider load, waits the divider latency, captures the quotient and returns it with a one-cycle done strobe to the served requester. It sits between client logic and the divider datapath. The divider's own reset is driven separately.

Parameters:
W, 4, operand/quotient width; must match the divider.
DIV_LAT, 5, cycles from the cycle after div_ld until div_y is valid; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
req0  in  1  requester 0 request, level.
a0  in  W  requester 0 dividend.
b0  in  W  requester 0 divisor.
req1  in  1  requester 1 request, level.
a1  in  W  requester 1 dividend.
b1  in  W  requester 1 divisor.
done0  out  1  one-cycle strobe: result for requester 0 valid.
done1  out  1  one-cycle strobe: result for requester 1 valid.
q  out  W  quotient; valid only while done0 or done1 is high.
dz  out  1  divide-by-zero flag; valid with done (see Optional Feature).
busy  out  1  high in every state except IDLE.
div_ld  out  1  load strobe to the divider.
div_a  out  W  dividend to the divider (latched operand).
div_b  out  W  divisor to the divider (latched operand).
div_y  in  W  quotient from the divider.

Behaviour:
- Reset is asynchronous, active-low (rst=0):
  - state=IDLE; all outputs 0; latched operands 0.
  - RR pointer set to favour requester 0; wait counter 0.
  - Applies immediately, including mid-operation. No done is issued for an aborted operation.
- All outputs are registered or decoded from registered state. No combinational path from req*/a*/b* to any output.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise grant one requester:
    - only one high: grant it;
    - both high: grant the one not served last. After reset, requester 0 wins.
  - Latch granted a/b into div_a/div_b and record the grant ID, then go to LOAD.
- LOAD:
  - div_ld=1 for exactly this cycle.
  - div_a/div_b stay stable from LOAD through DONE.
  - Counter loaded with DIV_LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - Exit to DONE after DIV_LAT cycles in WAIT.
- DONE:
  - q=div_y (captured at the LOAD/WAIT-to-DONE edge, held for this cycle).
  - done of the granted requester =1 for exactly one cycle; dz=0.
  - RR pointer updated to favour the other requester.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle 0 → LOAD cycle 1 → WAIT cycles 2..DIV_LAT+1 → DONE cycle DIV_LAT+2. Minimum issue interval is DIV_LAT+3 cycles.
- Requester rules:
  - Hold req and operands stable until done is seen.
  - Drop req at the clock edge ending the done cycle.
  - A req still high in the following IDLE cycle is a new request.
  - Operand changes after the IDLE grant are ignored.
- A non-granted requester keeps waiting. It is served next because of the RR pointer, so there is no starvation.
- Only one done is high in any cycle. done0 and done1 are never simultaneous.
- Arithmetic is unsigned. Quotient semantics come from the divider; the controller does not modify q except in the dz case.

Optional Feature:
Macro DIV_ARB_DZCHK_EN.
- Defined: in IDLE, if the granted divisor is 0:
  - skip LOAD/WAIT and go directly to DONE;
  - div_ld is never asserted for that request;
  - in DONE, q={W{1'b1}} and dz=1;
  - done, RR update and total latency (cycle 1) follow the normal DONE rules.
- Not defined:
  - zero divisors go through the divider normally;
  - q is whatever div_y returns;
  - dz is tied 0.

Test Plan:
1. rst released, req0=1 a0=13 b0=3, divider model latency 5 → div_ld high cycle 1 with div_a=13 div_b=3; done0=1 at cycle 7 with q=4; busy high cycles 1..7.
2. req0 (9/2) and req1 (15/5) raised together after reset → requester 0 served first (q=4), then requester 1 (q=3) granted in the next IDLE; done0 and done1 never overlap.
3. Both reqs held high for 6 operations → grant order 0,1,0,1,0,1; each done spaced DIV_LAT+3=8 cycles apart.
4. req1 a1=2 b1=7 → q=0 on done1; a1=15 b1=1 → q=15.
5. b0=0 a0=5:
   - with DIV_ARB_DZCHK_EN: done0 at cycle 1, q=4'hF, dz=1, div_ld never high;
   - without the macro: div_ld pulses, dz=0, q=div_y.
6. rst pulled low during WAIT → all outputs 0 asynchronously, no done0; after rst release with req0 still high, the request is reissued and completes with the correct quotient.
